// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - shared types, coin values and value lookup for the coin acceptor
package coin_pkg;

    localparam int RS1  = 1;
    localparam int RS2  = 2;
    localparam int RS5  = 5;
    localparam int RS10 = 10;

    localparam int SENSE_RS1  = 0;
    localparam int SENSE_RS2  = 1;
    localparam int SENSE_RS5  = 2;
    localparam int SENSE_RS10 = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        RELEASE  = 2'd3
    } acc_state_t;

    // Rupee value of a single-sensor pattern; anything that is not one-hot maps to 0
    function automatic logic [3:0] coin_lut(input logic [3:0] pat);
        logic [3:0] v;
        v = 4'd0;
        if (pat == (4'b0001 << SENSE_RS1))  v = 4'(RS1);
        if (pat == (4'b0001 << SENSE_RS2))  v = 4'(RS2);
        if (pat == (4'b0001 << SENSE_RS5))  v = 4'(RS5);
        if (pat == (4'b0001 << SENSE_RS10)) v = 4'(RS10);
        return v;
    endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// rtl/coin_acceptor_if.sv - sensor/enable inputs and coin result outputs (audit ports under COIN_AUDIT_EN)
interface coin_acceptor_if #(
    parameter int VALUE_W = 4
);
    logic [3:0]         coin_sense;
    logic               enable;
    logic               coin_valid;
    logic [VALUE_W-1:0] coin_value;
    logic               coin_reject;
    logic               busy;
`ifdef COIN_AUDIT_EN
    logic [15:0]        audit_coins;
    logic [15:0]        audit_rejects;
`endif

    modport master (
        output coin_sense, enable,
`ifdef COIN_AUDIT_EN
        input  audit_coins, audit_rejects,
`endif
        input  coin_valid, coin_value, coin_reject, busy
    );

    modport slave (
        input  coin_sense, enable,
`ifdef COIN_AUDIT_EN
        output audit_coins, audit_rejects,
`endif
        output coin_valid, coin_value, coin_reject, busy
    );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a W-bit vector of independent async bits
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two back-to-back flops give metastability a full cycle to resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounces coin sensors and emits one valid/reject pulse per coin; COIN_AUDIT_EN adds audit counters
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int VALUE_W         = 4
) (
    input  logic            clk,
    input  logic            rst,
    coin_acceptor_if.slave  bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    // Capture in IDLE is the first stable sample, so DEBOUNCE needs D-1 more
    localparam logic [CNT_W-1:0] CNT_EMIT = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]         s;
    acc_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [3:0]         pat_q, pat_d;
    logic               valid_q, valid_d;
    logic               reject_q, reject_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic               busy_q;

    sync_2ff #(.W(4)) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (bus.coin_sense),
        .q_o   (s)
    );

    // State, counter, captured pattern and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pat_q    <= '0;
            valid_q  <= 1'b0;
            reject_q <= 1'b0;
            value_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pat_q    <= pat_d;
            valid_q  <= valid_d;
            reject_q <= reject_d;
            value_q  <= value_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    // Next state; the pulse is decided on entry to EMIT so it is visible during EMIT
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pat_d    = pat_q;
        valid_d  = 1'b0;
        reject_d = 1'b0;
        value_d  = '0;
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        unique case (state_q)
            IDLE: begin
                if (s != 4'd0) begin
                    pat_d   = s;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (s != pat_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_EMIT) begin
                    state_d = EMIT;
                    if ($onehot(pat_q) && bus.enable) begin
                        valid_d = 1'b1;
                        value_d = VALUE_W'(coin_lut(pat_q));
                    end else begin
                        reject_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            EMIT: begin
                state_d = RELEASE;
                cnt_d   = '0;
            end
            RELEASE: begin
                if (s != 4'd0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.coin_valid  = valid_q;
    assign bus.coin_reject = reject_q;
    assign bus.coin_value  = value_q;
    assign bus.busy        = busy_q;

`ifdef COIN_AUDIT_EN
    logic [15:0] audit_coins_q;
    logic [15:0] audit_rejects_q;

    // Saturating pulse counters, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            audit_coins_q   <= '0;
            audit_rejects_q <= '0;
        end else begin
            if (valid_q && audit_coins_q != 16'hFFFF)
                audit_coins_q <= audit_coins_q + 16'd1;
            if (reject_q && audit_rejects_q != 16'hFFFF)
                audit_rejects_q <= audit_rejects_q + 16'd1;
        end
    end

    assign bus.audit_coins   = audit_coins_q;
    assign bus.audit_rejects = audit_rejects_q;
`endif

endmodule
